divider_64: RTL and testbench

Multi-cycle 64-bit integer divider implementing RV64M DIV/DIVU/REM/REMU semantics. It sits around the existing two's-complement negation stage `Complementarium_64`. Upstream, it uses that stage to take absolute values of signed operands. Downstream, it uses it to re-apply the result sign. Operands enter through a valid/ready handshake, a radix-2 restoring iteration runs for 64 cycles, and the result is held under a valid/ready handshake until consumed.

---
 rtl/divider_pkg.sv | 36 +++
 rtl/divider_64_complementarium.sv | 10 +
 rtl/divider_64.sv | 181 ++++++++++++++++++
 tb/tb_divider_64.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants, op encodings and FSM state type for the 64-bit divider.
package divider_pkg;

    localparam int DIV_W     = 64;
    localparam int DIV_ITERS = 64;
    localparam int CNT_W     = 7;

    // Counter preload: the last ITER cycle is the one where the counter reads 0.
    localparam logic [CNT_W-1:0] CNT_LAST = 7'(DIV_ITERS - 1);

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [DIV_W-1:0] INT_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_ITER = 3'd2,
        DIV_SIGN = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

    // DIV and REM (bit 0 clear) treat operands as two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

    // REM and REMU (bit 1 set) return the remainder instead of the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/divider_64_complementarium.sv
// Two's-complement negation stage shared by the divider for magnitude and sign fix-up.
module Complementarium_64 (
    input  logic [63:0] data_in,
    output logic [63:0] data_out
);

    // Plain negation: invert and add one.
    assign data_out = ~data_in + 64'd1;

endmodule

// File: rtl/divider_64.sv
// Multi-cycle radix-2 restoring divider with RV64M DIV/DIVU/REM/REMU semantics.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Producers hold valid and payload stable until that edge; in_ready is
// high only in IDLE outside reset, out_valid only in DONE, and result is stable
// for as long as out_valid is high.
module divider_64
    import divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIV_W-1:0] result,
    output div_state_e       dbg_state
);

    div_state_e       state_q,    state_d;
    logic [1:0]       op_q,       op_d;
    logic             quo_neg_q,  quo_neg_d;
    logic             rem_neg_q,  rem_neg_d;
    logic [DIV_W-1:0] a_raw_q,    a_raw_d;
    logic [DIV_W-1:0] b_raw_q,    b_raw_d;
    logic [DIV_W-1:0] rem_q,      rem_d;
    logic [DIV_W-1:0] quo_q,      quo_d;
    logic [DIV_W-1:0] dvs_q,      dvs_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [DIV_W-1:0] result_q,   result_d;

    // Both negation stages are time-shared: operand magnitudes in PREP,
    // quotient/remainder sign fix-up in SIGN.
    logic [DIV_W-1:0] neg_q_in, neg_q_out;
    logic [DIV_W-1:0] neg_r_in, neg_r_out;

    assign neg_q_in = (state_q == DIV_SIGN) ? quo_q : a_raw_q;
    assign neg_r_in = (state_q == DIV_SIGN) ? rem_q : b_raw_q;

    Complementarium_64 u_neg_quo (
        .data_in  (neg_q_in),
        .data_out (neg_q_out)
    );

    Complementarium_64 u_neg_rem (
        .data_in  (neg_r_in),
        .data_out (neg_r_out)
    );

    // One restoring step: the bit shifted out of rem is kept as the 65th bit of
    // the trial so large divisors never lose the carry.
    logic [2*DIV_W-1:0] pair_shl;
    logic [DIV_W:0]     partial;
    logic [DIV_W:0]     trial;

    assign pair_shl = {rem_q, quo_q} << 1;
    assign partial  = {rem_q[DIV_W-1], pair_shl[2*DIV_W-1:DIV_W]};
    assign trial    = partial - {1'b0, dvs_q};

    // Accept-time special-case decode on the live inputs.
    logic in_div_zero;
    logic in_overflow;

    assign in_div_zero = (divisor == '0);
    assign in_overflow = op_is_signed(op) && (dividend == INT_MIN) && (divisor == '1);

    // Next-state and datapath update for every FSM state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        a_raw_d   = a_raw_q;
        b_raw_d   = b_raw_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        case (state_q)
            DIV_IDLE: begin
                if (in_valid) begin
                    op_d      = op;
                    a_raw_d   = dividend;
                    b_raw_d   = divisor;
                    quo_neg_d = op_is_signed(op) && (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
                    rem_neg_d = op_is_signed(op) && dividend[DIV_W-1];
                    if (in_div_zero) begin
                        result_d = op_is_rem(op) ? dividend : '1;
                        state_d  = DIV_DONE;
                    end else if (in_overflow) begin
                        result_d = op_is_rem(op) ? '0 : INT_MIN;
                        state_d  = DIV_DONE;
                    end else begin
                        state_d  = DIV_PREP;
                    end
                end
            end

            DIV_PREP: begin
                quo_d   = rem_neg_q ? neg_q_out : a_raw_q;
                dvs_d   = (op_is_signed(op_q) && b_raw_q[DIV_W-1]) ? neg_r_out : b_raw_q;
                rem_d   = '0;
                cnt_d   = CNT_LAST;
                state_d = DIV_ITER;
            end

            DIV_ITER: begin
                if (!trial[DIV_W]) begin
                    rem_d = trial[DIV_W-1:0];
                    quo_d = {pair_shl[DIV_W-1:1], 1'b1};
                end else begin
                    rem_d = partial[DIV_W-1:0];
                    quo_d = pair_shl[DIV_W-1:0];
                end
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == '0) begin
                    state_d = DIV_SIGN;
                end
            end

            DIV_SIGN: begin
                if (op_is_rem(op_q)) begin
                    result_d = rem_neg_q ? neg_r_out : rem_q;
                end else begin
                    result_d = quo_neg_q ? neg_q_out : quo_q;
                end
                state_d = DIV_DONE;
            end

            DIV_DONE: begin
                if (out_ready) begin
                    state_d = DIV_IDLE;
                end
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            op_q      <= OP_DIV;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            a_raw_q   <= a_raw_d;
            b_raw_q   <= b_raw_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == DIV_IDLE) && !rst;
    assign out_valid = (state_q == DIV_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_divider_64.sv
// Directed and randomised check of divider_64 against a behavioural RV64M model.
module tb_divider_64;
  import divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  div_state_e  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  divider_64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural RV64M reference: plain / and % with the RISC-V special cases.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    case (o)
      2'b00:   return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : $unsigned(sa / sb));
      2'b01:   return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 64'd0 : $unsigned(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Runs one op; lat counts rising edges from the accept edge (=1) up to the
  // first edge after which out_valid is seen, i.e. the spec's cycle number.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] b, input bit early,
                        output logic [63:0] res, output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, " in_ready_before"}, 64'(in_ready), 64'd1);
    op        = o;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = early;
    @(posedge clk); #1;
    lat = 1;
    // Keep valid high with scrambled payload: the block must ignore it now.
    op       = 2'($urandom_range(0, 3));
    dividend = {$urandom(), $urandom()};
    divisor  = {$urandom(), $urandom()};
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid  = 1'b0;
    res       = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid_after_hs"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] r;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] held;
    logic [1:0]  o;
    int          lat;
    bit          seen;
    bit          special;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = OP_DIV;
    dividend  = '0;
    divisor   = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst state", 64'(dbg_state), 64'(DIV_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst in_ready", 64'(in_ready), 64'd1);

    // Directed vectors.
    run_op("div_100_7", OP_DIV, 64'd100, 64'd7, 1'b0, r, lat);
    chk("div_100_7 result", r, 64'd14);
    chk("div_100_7 latency", 64'(lat), 64'd67);

    run_op("rem_m20_6", OP_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 1'b0, r, lat);
    chk("rem_m20_6 result", r, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op("div_m20_6", OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 1'b1, r, lat);
    chk("div_m20_6 result", r, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_m20_6 latency", 64'(lat), 64'd67);

    run_op("divu_max_2", OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, r, lat);
    chk("divu_max_2 result", r, 64'h7FFF_FFFF_FFFF_FFFF);

    run_op("remu_7_m1", OP_REMU, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r, lat);
    chk("remu_7_m1 result", r, 64'd7);

    run_op("div_5_0", OP_DIV, 64'd5, 64'd0, 1'b0, r, lat);
    chk("div_5_0 result", r, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("div_5_0 latency", 64'(lat), 64'd1);

    run_op("remu_5_0", OP_REMU, 64'd5, 64'd0, 1'b0, r, lat);
    chk("remu_5_0 result", r, 64'd5);
    chk("remu_5_0 latency", 64'(lat), 64'd1);

    run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r, lat);
    chk("div_ovf result", r, 64'h8000_0000_0000_0000);
    chk("div_ovf latency", 64'(lat), 64'd1);

    run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, r, lat);
    chk("rem_ovf result", r, 64'd0);
    chk("rem_ovf latency", 64'(lat), 64'd1);

    // Backpressure: result held in DONE while out_ready stays low.
    op       = OP_DIVU;
    dividend = 64'd1000;
    divisor  = 64'd10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    dividend = 64'd77;
    divisor  = 64'd1;
    lat      = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 64'(lat), 64'd67);
    held = result;
    chk("bp result", held, 64'd100);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d result", k), result, 64'd100);
      chk($sformatf("bp hold%0d out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release out_valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of ITER aborts silently.
    op       = OP_DIV;
    dividend = 64'd1000;
    divisor  = 64'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("midrst state_before", 64'(dbg_state), 64'(DIV_ITER));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst in_ready", 64'(in_ready), 64'd0);
    chk("midrst state", 64'(dbg_state), 64'(DIV_IDLE));
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst no_out_valid", 64'(seen), 64'd0);
    run_op("div_9_3", OP_DIV, 64'd9, 64'd3, 1'b0, r, lat);
    chk("div_9_3 result", r, 64'd3);

    // Random ops across all modes and operand classes.
    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 64'($urandom_range(0, 1000));
        1:       a = -64'($urandom_range(0, 1000));
        2:       a = 64'h8000_0000_0000_0000;
        default: a = {$urandom(), $urandom()};
      endcase
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1:       b = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       b = 64'($urandom_range(1, 50));
        3:       b = -64'($urandom_range(1, 50));
        4:       b = {32'd0, $urandom()};
        default: b = {$urandom(), $urandom()};
      endcase
      special = (b == 64'd0) ||
                (!o[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
      run_op($sformatf("rand%0d", i), o, a, b, i[0], r, lat);
      chk($sformatf("rand%0d op%0d a=%h b=%h result", i, o, a, b), r, model(o, a, b));
      chk($sformatf("rand%0d latency", i), 64'(lat), special ? 64'd1 : 64'd67);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
